// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: counts from lo to hi and back for a programmed number of
// sweeps. It advances one step per cycle while tick is high, supports abort, and
// rejects bad configurations with a one-cycle cfg_err pulse.
module updown_sweep_ctrl #(
   parameter int WIDTH = 4,
   parameter int SWP_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             tick,
   input  logic [WIDTH-1:0] lo_lim,
   input  logic [WIDTH-1:0] hi_lim,
   input  logic [SWP_W-1:0] num_sweeps,
   output logic [WIDTH-1:0] count,
   output logic             up_down_sw,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic [SWP_W-1:0] sweep_idx
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_DOWN = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
   localparam logic [SWP_W-1:0] SWP_ONE = SWP_W'(1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic             dir_reg, dir_next;
   logic             cfg_err_reg, cfg_err_next;
   logic [SWP_W-1:0] sweep_reg, sweep_next;
   logic [WIDTH-1:0] lo_reg, lo_next;
   logic [WIDTH-1:0] hi_reg, hi_next;
   logic [SWP_W-1:0] nsw_reg, nsw_next;

   logic [WIDTH-1:0] count_inc;
   logic [WIDTH-1:0] count_dec;
   logic [SWP_W-1:0] sweep_inc;

   // The run only ever steps toward a limit that it has not yet reached.
   // This keeps the increment and decrement results inside [lo, hi], so
   // no wrap guard is needed.
   assign count_inc = count_reg + CNT_ONE;
   assign count_dec = count_reg - CNT_ONE;
   assign sweep_inc = sweep_reg + SWP_ONE;

   // State and datapath registers; reset clears everything, including the latched limits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= S_IDLE;
         count_reg   <= '0;
         dir_reg     <= 1'b0;
         cfg_err_reg <= 1'b0;
         sweep_reg   <= '0;
         lo_reg      <= '0;
         hi_reg      <= '0;
         nsw_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         dir_reg     <= dir_next;
         cfg_err_reg <= cfg_err_next;
         sweep_reg   <= sweep_next;
         lo_reg      <= lo_next;
         hi_reg      <= hi_next;
         nsw_reg     <= nsw_next;
      end
   end

   // Next-state logic. Abort overrides everything, and the count holds on abort.
   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      dir_next     = dir_reg;
      cfg_err_next = 1'b0;
      sweep_next   = sweep_reg;
      lo_next      = lo_reg;
      hi_next      = hi_reg;
      nsw_next     = nsw_reg;

      if (abort) begin
         state_next = S_IDLE;
         dir_next   = 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  if ((lo_lim >= hi_lim) || (num_sweeps == '0)) begin
                     cfg_err_next = 1'b1;
                  end else begin
                     lo_next    = lo_lim;
                     hi_next    = hi_lim;
                     nsw_next   = num_sweeps;
                     count_next = lo_lim;
                     sweep_next = '0;
                     dir_next   = 1'b1;
                     state_next = S_UP;
                  end
               end
            end
            S_UP: begin
               if (tick) begin
                  count_next = count_inc;
                  if (count_inc == hi_reg) begin
                     state_next = S_DOWN;
                     dir_next   = 1'b0;
                  end
               end
            end
            S_DOWN: begin
               if (tick) begin
                  count_next = count_dec;
                  if (count_dec == lo_reg) begin
                     sweep_next = sweep_inc;
                     if (sweep_inc == nsw_reg) begin
                        state_next = S_DONE;
                     end else begin
                        state_next = S_UP;
                        dir_next   = 1'b1;
                     end
                  end
               end
            end
            S_DONE: begin
               state_next = S_IDLE;
            end
            default: begin
               state_next = S_IDLE;
               dir_next   = 1'b0;
            end
         endcase
      end
   end

   // busy and done decode directly from the state register, so reset clears them at once.
   always_comb begin
      busy = (state_reg == S_UP) || (state_reg == S_DOWN);
      done = (state_reg == S_DONE);
   end

   assign count      = count_reg;
   assign up_down_sw = dir_reg;
   assign cfg_err    = cfg_err_reg;
   assign sweep_idx  = sweep_reg;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed, table-driven bench for updown_sweep_ctrl with hand-computed expectations.
module tb_updown_sweep_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic       abort;
   logic       tick;
   logic [3:0] lo_lim;
   logic [3:0] hi_lim;
   logic [3:0] num_sweeps;
   logic [3:0] count;
   logic       up_down_sw;
   logic       busy;
   logic       done;
   logic       cfg_err;
   logic [3:0] sweep_idx;

   typedef struct {
      logic       start;
      logic       abort;
      logic       tick;
      logic [3:0] lo;
      logic [3:0] hi;
      logic [3:0] n;
      logic [3:0] e_count;
      logic       e_ud;
      logic       e_busy;
      logic       e_done;
      logic       e_cfg;
      logic [3:0] e_sw;
   } vec_t;

   vec_t tbl [0:63];
   int   ntbl = 0;
   int   n_vec = 0;
   int   n_miss = 0;

   updown_sweep_ctrl #(.WIDTH(4), .SWP_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .tick       (tick),
      .lo_lim     (lo_lim),
      .hi_lim     (hi_lim),
      .num_sweeps (num_sweeps),
      .count      (count),
      .up_down_sw (up_down_sw),
      .busy       (busy),
      .done       (done),
      .cfg_err    (cfg_err),
      .sweep_idx  (sweep_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic add(input logic s, input logic a, input logic t,
                      input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] n,
                      input logic [3:0] c, input logic ud, input logic b,
                      input logic d, input logic ce, input logic [3:0] sw);
      tbl[ntbl].start   = s;
      tbl[ntbl].abort   = a;
      tbl[ntbl].tick    = t;
      tbl[ntbl].lo      = lo;
      tbl[ntbl].hi      = hi;
      tbl[ntbl].n       = n;
      tbl[ntbl].e_count = c;
      tbl[ntbl].e_ud    = ud;
      tbl[ntbl].e_busy  = b;
      tbl[ntbl].e_done  = d;
      tbl[ntbl].e_cfg   = ce;
      tbl[ntbl].e_sw    = sw;
      ntbl++;
   endtask

   // Compares all outputs against the expected record, one line per vector.
   task automatic compare(input string name, input vec_t v);
      logic [11:0] act;
      logic [11:0] exp;
      act = {count, up_down_sw, busy, done, cfg_err, sweep_idx};
      exp = {v.e_count, v.e_ud, v.e_busy, v.e_done, v.e_cfg, v.e_sw};
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got count=%0d ud=%0b busy=%0b done=%0b cfg_err=%0b sweep=%0d, required count=%0d ud=%0b busy=%0b done=%0b cfg_err=%0b sweep=%0d",
                  name, count, up_down_sw, busy, done, cfg_err, sweep_idx,
                  v.e_count, v.e_ud, v.e_busy, v.e_done, v.e_cfg, v.e_sw);
      end else begin
         $display("ok   %s: count=%0d ud=%0b busy=%0b done=%0b cfg_err=%0b sweep=%0d",
                  name, count, up_down_sw, busy, done, cfg_err, sweep_idx);
      end
   endtask

   // Drives one cycle of inputs, clocks, and samples 1 time unit after the edge.
   task automatic run_vec(input string name, input vec_t v);
      start      = v.start;
      abort      = v.abort;
      tick       = v.tick;
      lo_lim     = v.lo;
      hi_lim     = v.hi;
      num_sweeps = v.n;
      @(posedge clk);
      #1;
      compare(name, v);
   endtask

   function automatic vec_t mk(input logic s, input logic a, input logic t,
                               input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] n,
                               input logic [3:0] c, input logic ud, input logic b,
                               input logic d, input logic ce, input logic [3:0] sw);
      vec_t v;
      v.start = s; v.abort = a; v.tick = t; v.lo = lo; v.hi = hi; v.n = n;
      v.e_count = c; v.e_ud = ud; v.e_busy = b; v.e_done = d; v.e_cfg = ce; v.e_sw = sw;
      return v;
   endfunction

   initial begin
      vec_t v;
      int   p;
      int   tk;
      logic [3:0] alt_cnt [0:6];

      // Basic lo=2, hi=5, single sweep with tick held high.
      add(1,0,1, 2,5,1,  2,1,1,0,0,0);
      add(0,0,1, 2,5,1,  3,1,1,0,0,0);
      add(0,0,1, 2,5,1,  4,1,1,0,0,0);
      add(0,0,1, 2,5,1,  5,0,1,0,0,0);
      add(0,0,1, 2,5,1,  4,0,1,0,0,0);
      add(0,0,1, 2,5,1,  3,0,1,0,0,0);
      add(0,0,1, 2,5,1,  2,0,0,1,0,1);
      add(0,0,1, 2,5,1,  2,0,0,0,0,1);
      // Rejected configurations produce a single cfg_err pulse and change nothing else.
      add(1,0,0, 5,5,1,  2,0,0,0,1,1);
      add(0,0,0, 5,5,1,  2,0,0,0,0,1);
      add(1,0,0, 3,6,0,  2,0,0,0,1,1);
      add(0,0,0, 3,6,0,  2,0,0,0,0,1);
      add(1,0,1, 6,5,1,  2,0,0,0,1,1);
      add(0,0,1, 6,5,1,  2,0,0,0,0,1);
      // Abort in DOWN at count=3 together with tick: count holds at 3.
      add(1,0,0, 1,4,1,  1,1,1,0,0,0);
      add(0,0,1, 1,4,1,  2,1,1,0,0,0);
      add(0,0,1, 1,4,1,  3,1,1,0,0,0);
      add(0,0,1, 1,4,1,  4,0,1,0,0,0);
      add(0,0,1, 1,4,1,  3,0,1,0,0,0);
      add(1,1,1, 1,4,1,  3,0,0,0,0,0);
      add(0,0,1, 1,4,1,  3,0,0,0,0,0);
      // Start a new run from lo=0; a restart and new limits mid-run are ignored.
      add(1,0,1, 0,2,1,  0,1,1,0,0,0);
      add(1,0,1, 7,9,1,  1,1,1,0,0,0);
      add(0,0,1, 7,9,1,  2,0,1,0,0,0);
      add(0,0,0, 7,9,1,  2,0,1,0,0,0);
      add(0,0,1, 7,9,1,  1,0,1,0,0,0);
      add(0,0,1, 7,9,1,  0,0,0,1,0,1);
      add(0,0,1, 7,9,1,  0,0,0,0,0,1);
      // With hi = lo + 1, each sweep takes 2 ticks; run two sweeps.
      add(1,0,1, 3,4,2,  3,1,1,0,0,0);
      add(0,0,1, 3,4,2,  4,0,1,0,0,0);
      add(0,0,1, 3,4,2,  3,1,1,0,0,1);
      add(0,0,1, 3,4,2,  4,0,1,0,0,1);
      add(0,0,1, 3,4,2,  3,0,0,1,0,2);
      // In IDLE, start together with abort is not accepted.
      add(1,1,0, 1,3,1,  3,0,0,0,0,2);

      start = 0; abort = 0; tick = 0; lo_lim = 0; hi_lim = 0; num_sweeps = 0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      compare("reset_state", mk(0,0,0,0,0,0, 0,0,0,0,0,0));
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < ntbl; i++) begin
         run_vec($sformatf("table[%0d]", i), tbl[i]);
      end

      // Full range 0..15, two sweeps: 30 ticks per sweep, 60 ticks in total, never wrapping past 15.
      run_vec("full_start", mk(1,0,1, 0,15,2, 0,1,1,0,0,0));
      for (int k = 1; k <= 60; k++) begin
         p = k % 30;
         v = mk(0,0,1, 0,15,2, 4'(p <= 15 ? p : 30 - p),
                ((p < 15) && (k != 60)) ? 1'b1 : 1'b0,
                (k != 60) ? 1'b1 : 1'b0,
                (k == 60) ? 1'b1 : 1'b0,
                1'b0, 4'(k / 30));
         run_vec($sformatf("full_tick%0d", k), v);
      end
      run_vec("full_idle", mk(0,0,1, 0,15,2, 0,0,0,0,0,2));

      // lo=1, hi=4, tick toggling each cycle: the count moves only on odd cycles.
      alt_cnt[0] = 4'd1; alt_cnt[1] = 4'd2; alt_cnt[2] = 4'd3; alt_cnt[3] = 4'd4;
      alt_cnt[4] = 4'd3; alt_cnt[5] = 4'd2; alt_cnt[6] = 4'd1;
      run_vec("alt_start", mk(1,0,0, 1,4,1, 1,1,1,0,0,0));
      for (int j = 1; j <= 11; j++) begin
         tk = (j + 1) / 2;
         v = mk(0,0,(j % 2 == 1), 1,4,1, alt_cnt[tk],
                (tk <= 2) ? 1'b1 : 1'b0,
                (j < 11) ? 1'b1 : 1'b0,
                (j == 11) ? 1'b1 : 1'b0,
                1'b0, (j >= 11) ? 4'd1 : 4'd0);
         run_vec($sformatf("alt_cyc%0d", j), v);
      end
      run_vec("alt_idle", mk(0,0,0, 1,4,1, 1,0,0,0,0,1));

      // Asynchronous reset between edges in the middle of UP, then restart.
      run_vec("rst_start", mk(1,0,1, 2,5,1, 2,1,1,0,0,0));
      run_vec("rst_tick1", mk(0,0,1, 2,5,1, 3,1,1,0,0,0));
      run_vec("rst_tick2", mk(0,0,1, 2,5,1, 4,1,1,0,0,0));
      #2;
      reset = 1'b0;
      #1;
      compare("rst_async", mk(0,0,1, 2,5,1, 0,0,0,0,0,0));
      @(posedge clk);
      #1;
      compare("rst_held", mk(0,0,1, 2,5,1, 0,0,0,0,0,0));
      @(negedge clk);
      reset = 1'b1;
      run_vec("rst_restart", mk(1,0,1, 1,3,1, 1,1,1,0,0,0));
      run_vec("rst_run", mk(0,0,1, 1,3,1, 2,1,1,0,0,0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
